multiword_add_sequencer: RTL

Word-serial multi-precision add/subtract controller. It sequences one `DATA_WIDTH`-bit adder slice over `NUM_WORDS` operand words, least-significant word first, carrying between words. It uses a `carry_extractor` instance to recover per-bit carries, which give the final carry-out and signed overflow. It sits between an operand-streaming source (ALU microcode or a load unit) and a result sink, with valid/ready handshakes on every side.

---
 rtl/multiword_add_sequencer_pkg.sv | 15 +
 rtl/multiword_add_sequencer_carry_extractor.sv | 16 +
 rtl/multiword_add_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/multiword_add_sequencer_pkg.sv
// Shared types and sizing helpers for the word-serial multi-precision adder.
package multiword_add_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} madd_state_t;

  // A single-word operation still needs a 1-bit counter.
  function automatic int cnt_width(input int num_words);
    if (num_words > 1) begin
      return $clog2(num_words);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/multiword_add_sequencer_carry_extractor.sv
// Recovers the carry into every bit position of an adder from its operands and sum.
module carry_extractor #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] sum,
  output logic [DATA_WIDTH-1:0] carries
);

  // sum[i] = a[i] ^ b[i] ^ cin[i], so the incoming carry falls out of the xor.
  always_comb begin
    carries = a ^ b ^ sum;
  end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Word-serial add/subtract sequencer: one adder slice over NUM_WORDS words, LSW first.
module multiword_add_sequencer
  import multiword_add_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_sub,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic                  out_last,
  output logic                  out_carry,
  output logic                  out_overflow
);

  localparam int CNT_W = cnt_width(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  madd_state_t              state_r;
  logic                     sub_r;
  logic                     carry_r;
  logic [CNT_W-1:0]         word_cnt_r;

  logic [DATA_WIDTH-1:0]    b_eff_s;
  logic [DATA_WIDTH-1:0]    sum_s;
  logic                     carry_msb_s;
  logic [DATA_WIDTH-2:0]    carries_unused_s;
  logic                     cout_s;
  logic                     ovf_s;
  logic                     is_last_s;
  logic                     cmd_fire_s;
  logic                     in_fire_s;

  // Only the carry into the MSB matters for carry-out and signed overflow.
  carry_extractor #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_carry_extractor (
    .a       (in_a),
    .b       (b_eff_s),
    .sum     (sum_s),
    .carries ({carry_msb_s, carries_unused_s})
  );

  // Slice arithmetic, handshakes and last-word detection.
  always_comb begin
    b_eff_s    = in_b ^ {DATA_WIDTH{sub_r}};
    sum_s      = in_a + b_eff_s + DATA_WIDTH'(carry_r);
    cout_s     = (in_a[DATA_WIDTH-1] & b_eff_s[DATA_WIDTH-1]) |
                 (carry_msb_s & (in_a[DATA_WIDTH-1] ^ b_eff_s[DATA_WIDTH-1]));
    ovf_s      = carry_msb_s ^ cout_s;
    is_last_s  = (word_cnt_r == LAST_IDX);
    cmd_ready  = (state_r == IDLE);
    in_ready   = (state_r == RUN) && (!out_valid || out_ready);
    cmd_fire_s = cmd_valid && cmd_ready;
    in_fire_s  = in_valid && in_ready;
  end

  // Sequencer state, inter-word carry and the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      sub_r        <= 1'b0;
      carry_r      <= 1'b0;
      word_cnt_r   <= CNT_W'(0);
      out_valid    <= 1'b0;
      out_sum      <= {DATA_WIDTH{1'b0}};
      out_last     <= 1'b0;
      out_carry    <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_fire_s) begin
            sub_r      <= cmd_sub;
            carry_r    <= cmd_sub;
            word_cnt_r <= CNT_W'(0);
            state_r    <= RUN;
          end
        end
        RUN: begin
          if (in_fire_s) begin
            carry_r <= cout_s;
            if (is_last_s) begin
              word_cnt_r <= CNT_W'(0);
              state_r    <= IDLE;
            end else begin
              word_cnt_r <= word_cnt_r + CNT_W'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase

      // A load in the same cycle as a drain wins, keeping full throughput.
      if (in_fire_s) begin
        out_valid    <= 1'b1;
        out_sum      <= sum_s;
        out_last     <= is_last_s;
        out_carry    <= is_last_s ? cout_s : 1'b0;
        out_overflow <= is_last_s ? ovf_s : 1'b0;
      end else if (out_ready) begin
        out_valid    <= 1'b0;
      end
    end
  end

endmodule
